pipe_stage_buf: RTL

- Parametrised pipeline-stage register for the core. It is the successor to the fixed per-stage enable/reset registers.
- Carries instruction, PC and a packed control/data payload of configurable width. Uses a valid/ready handshake with 1..4 entries of elastic buffering.
- Flush turns the stage into a bubble: instr_o becomes NOP, valid_o deasserts.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_buf.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline-stage register with 1..4 entries, valid/ready handshake and flush.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble counters (stall_cnt_o, bubble_cnt_o).
module pipe_stage_buf #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [31:0]       instr_i,
  input  logic [31:0]       pc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [31:0]       instr_o,
  output logic [31:0]       pc_o,
  output logic [DATA_W-1:0] data_o,
  output logic [2:0]        count_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
`endif
);

  localparam int unsigned     PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef struct packed {
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_stage_buf: DEPTH must be in 1..4");
  end

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [2:0]       count;
  logic             empty;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == 3'd0);
  assign valid_o = !empty;
  assign count_o = count;

  // A single register must be able to take a new entry while its current one leaves.
  if (DEPTH == 1) begin : g_ready_reg
    assign ready_o = empty || ready_i;
  end else begin : g_ready_skid
    assign ready_o = (count < 3'(DEPTH));
  end

  assign push = valid_i && ready_o && !flush_i;
  assign pop  = valid_o && ready_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count  <= 3'd0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush_i) begin
      count  <= 3'd0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  // NOTE: payload storage has no reset; an entry is only visible once count covers it.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{instr: instr_i, pc: pc_i, data: data_i};
  end

  // NOTE: every field gets a default before the conditional override, so no latch is inferred.
  always_comb begin
    head = mem[rd_ptr];
    if (empty) head = '{instr: NOP_INSTR, pc: '0, data: '0};
  end

  assign instr_o = head.instr;
  assign pc_o    = head.pc;
  assign data_o  = head.data;

`ifdef PIPE_STAGE_PERF_EN
  // Counters survive flush; they only clear on reset and stick at all-ones.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (valid_o && !ready_i && stall_cnt_o != '1)  stall_cnt_o  <= stall_cnt_o + 32'd1;
      if (ready_i && !valid_o && bubble_cnt_o != '1) bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule
